clock_timekeeper: RTL and testbench

Time-of-day sequencer for the digital clock: holds the current time as BCD digit pairs (hours, minutes, seconds) and advances them on a one-second strobe. It also runs the user set-mode state machine driven by two pre-debounced button pulses. Its seconds digits feed the seconds LED controller; its minute and hour digits feed the matching LED controllers.

---
 rtl/clock_timekeeper_pkg.sv | 27 ++
 rtl/clock_timekeeper_if.sv | 30 +++
 rtl/clock_timekeeper_bcd_pair_counter.sv | 44 ++++
 rtl/clock_timekeeper.sv | 125 ++++++++++++
 tb/tb_clock_timekeeper.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/clock_timekeeper_pkg.sv
// Shared mode encoding, time limits and digit widths for the clock timekeeper.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_HOURS = 2'd1,
        SET_MINS  = 2'd2
    } mode_t;

    localparam int SEC_MAX    = 59;
    localparam int MIN_MAX    = 59;
    localparam int HOUR_MAX   = 23;
    localparam int UNITS_MAX  = 9;

    localparam int SEC_TENS_MAX            = SEC_MAX / 10;
    localparam int SEC_UNITS_AT_TENS_MAX   = SEC_MAX % 10;
    localparam int MIN_TENS_MAX            = MIN_MAX / 10;
    localparam int MIN_UNITS_AT_TENS_MAX   = MIN_MAX % 10;
    localparam int HOUR_TENS_MAX           = HOUR_MAX / 10;
    localparam int HOUR_UNITS_AT_TENS_MAX  = HOUR_MAX % 10;

    localparam int UNITS_W     = 4;
    localparam int SEC_TENS_W  = 3;
    localparam int MIN_TENS_W  = 3;
    localparam int HOUR_TENS_W = 2;

endpackage

// File: rtl/clock_timekeeper_if.sv
// Button/strobe inputs and BCD time outputs of the timekeeper, bundled as one port.
interface clock_timekeeper_if;
    import clock_pkg::*;

    logic                   tick_1hz;
    logic                   btn_mode;
    logic                   btn_inc;
    logic [UNITS_W-1:0]     rightSecs;
    logic [SEC_TENS_W-1:0]  leftSecs;
    logic [UNITS_W-1:0]     rightMins;
    logic [MIN_TENS_W-1:0]  leftMins;
    logic [UNITS_W-1:0]     rightHours;
    logic [HOUR_TENS_W-1:0] leftHours;
    logic [1:0]             mode;
    logic                   blink;
    logic                   day_wrap;

    modport master (
        output tick_1hz, btn_mode, btn_inc,
        input  rightSecs, leftSecs, rightMins, leftMins, rightHours, leftHours,
        input  mode, blink, day_wrap
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc,
        output rightSecs, leftSecs, rightMins, leftMins, rightHours, leftHours,
        output mode, blink, day_wrap
    );

endinterface

// File: rtl/clock_timekeeper_bcd_pair_counter.sv
// Two-digit BCD counter; wrap is combinational so the next stage can carry on the same edge.
module bcd_pair_counter
    import clock_pkg::*;
#(
    parameter int TENS_MAX          = 5,
    parameter int UNITS_AT_TENS_MAX = 9,
    parameter int TENS_W            = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [TENS_W-1:0]  tens,
    output logic [UNITS_W-1:0] units,
    output logic               wrap
);

    logic [TENS_W-1:0]  r_tens;
    logic [UNITS_W-1:0] r_units;
    logic               w_atMax;

    assign w_atMax = (r_tens == TENS_W'(TENS_MAX)) && (r_units == UNITS_W'(UNITS_AT_TENS_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tens  <= '0;
            r_units <= '0;
        end else if (inc) begin
            if (w_atMax) begin
                r_tens  <= '0;
                r_units <= '0;
            end else if (r_units == UNITS_W'(UNITS_MAX)) begin
                r_units <= '0;
                r_tens  <= r_tens + 1'b1;
            end else begin
                r_units <= r_units + 1'b1;
            end
        end
    end

    assign tens  = r_tens;
    assign units = r_units;
    assign wrap  = inc && w_atMax;

endmodule

// File: rtl/clock_timekeeper.sv
// Time-of-day sequencer with RUN/SET_HOURS/SET_MINS mode FSM.
// Optional macro CLOCK_BLINK_EN adds a blink register toggled by ticks in set modes.
module clock_timekeeper
    import clock_pkg::*;
#(
    parameter bit SEC_WRAP_PULSE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    clock_timekeeper_if.slave  bus
);

    mode_t r_state;
    mode_t w_nextState;

    logic w_runMode;
    logic w_secInc, w_minInc, w_hourInc;
    logic w_secWrap, w_minWrap, w_hourWrap;
    logic w_secClear;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (bus.btn_mode) begin
            case (r_state)
                RUN:       w_nextState = SET_HOURS;
                SET_HOURS: w_nextState = SET_MINS;
                SET_MINS:  w_nextState = RUN;
                default:   w_nextState = RUN;
            endcase
        end
    end

    // Carries only ripple in RUN; set-mode increments are dropped when btn_mode also fires.
    assign w_runMode  = (r_state == RUN);
    assign w_secInc   = w_runMode && bus.tick_1hz;
    assign w_minInc   = w_runMode ? w_secWrap
                                  : ((r_state == SET_MINS) && bus.btn_inc && !bus.btn_mode);
    assign w_hourInc  = w_runMode ? w_minWrap
                                  : ((r_state == SET_HOURS) && bus.btn_inc && !bus.btn_mode);
    assign w_secClear = rst || ((r_state == SET_MINS) && bus.btn_mode);

    bcd_pair_counter #(
        .TENS_MAX          (SEC_TENS_MAX),
        .UNITS_AT_TENS_MAX (SEC_UNITS_AT_TENS_MAX),
        .TENS_W            (SEC_TENS_W)
    ) u_secs (
        .clk   (clk),
        .rst   (w_secClear),
        .inc   (w_secInc),
        .tens  (bus.leftSecs),
        .units (bus.rightSecs),
        .wrap  (w_secWrap)
    );

    bcd_pair_counter #(
        .TENS_MAX          (MIN_TENS_MAX),
        .UNITS_AT_TENS_MAX (MIN_UNITS_AT_TENS_MAX),
        .TENS_W            (MIN_TENS_W)
    ) u_mins (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_minInc),
        .tens  (bus.leftMins),
        .units (bus.rightMins),
        .wrap  (w_minWrap)
    );

    bcd_pair_counter #(
        .TENS_MAX          (HOUR_TENS_MAX),
        .UNITS_AT_TENS_MAX (HOUR_UNITS_AT_TENS_MAX),
        .TENS_W            (HOUR_TENS_W)
    ) u_hours (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hourInc),
        .tens  (bus.leftHours),
        .units (bus.rightHours),
        .wrap  (w_hourWrap)
    );

    assign bus.mode = r_state;

    generate
        if (SEC_WRAP_PULSE) begin : g_dayWrap
            logic r_dayWrap;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dayWrap <= 1'b0;
                end else begin
                    r_dayWrap <= w_runMode && w_hourWrap;
                end
            end
            assign bus.day_wrap = r_dayWrap;
        end else begin : g_noDayWrap
            assign bus.day_wrap = 1'b0;
        end
    endgenerate

`ifdef CLOCK_BLINK_EN
    logic r_blink;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink <= 1'b0;
        end else if (w_nextState == RUN) begin
            r_blink <= 1'b0;
        end else if (!w_runMode && bus.tick_1hz) begin
            r_blink <= ~r_blink;
        end
    end

    assign bus.blink = r_blink;
`else
    assign bus.blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_timekeeper.sv
// Randomized and directed bench for clock_timekeeper against a seconds-of-day reference model.
module tb_clock_timekeeper;

`ifdef CLOCK_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    clock_timekeeper_if bus ();

    clock_timekeeper #(.SEC_WRAP_PULSE(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecCount  = 0;
    int missCount = 0;

    int hh = 0, mm = 0, ss = 0;
    int modeExp = 0;
    int blinkExp = 0;
    int wrapExp = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vecCount++;
        if (observed != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t, model %0d:%0d:%0d mode %0d)",
                     tag, observed, expected, $time, hh, mm, ss, modeExp);
        end
    endtask

    // Reference model: time as seconds of day, set modes as modular field arithmetic.
    task automatic modelStep(input bit r, input bit tick, input bit md, input bit inc);
        int total;
        int oldMode;
        wrapExp = 0;
        if (r) begin
            hh = 0; mm = 0; ss = 0; modeExp = 0; blinkExp = 0;
            return;
        end
        oldMode = modeExp;
        case (oldMode)
            0: begin
                if (tick) begin
                    total = hh * 3600 + mm * 60 + ss + 1;
                    if (total == 86400) begin
                        total = 0;
                        wrapExp = 1;
                    end
                    hh = total / 3600;
                    mm = (total / 60) % 60;
                    ss = total % 60;
                end
                if (md) modeExp = 1;
            end
            1: begin
                if (md) modeExp = 2;
                else if (inc) hh = (hh + 1) % 24;
            end
            default: begin
                if (md) begin
                    modeExp = 0;
                    ss = 0;
                end else if (inc) begin
                    mm = (mm + 1) % 60;
                end
            end
        endcase
        if (modeExp == 0) blinkExp = 0;
        else if (oldMode != 0 && tick) blinkExp = blinkExp ^ 1;
    endtask

    task automatic applyStimulus(input bit r, input bit tick, input bit md, input bit inc);
        @(negedge clk);
        rst          = r;
        bus.tick_1hz = tick;
        bus.btn_mode = md;
        bus.btn_inc  = inc;
        @(posedge clk);
        modelStep(r, tick, md, inc);
        #1;
        checkOutput("rightSecs",  int'(bus.rightSecs),  ss % 10);
        checkOutput("leftSecs",   int'(bus.leftSecs),   ss / 10);
        checkOutput("rightMins",  int'(bus.rightMins),  mm % 10);
        checkOutput("leftMins",   int'(bus.leftMins),   mm / 10);
        checkOutput("rightHours", int'(bus.rightHours), hh % 10);
        checkOutput("leftHours",  int'(bus.leftHours),  hh / 10);
        checkOutput("mode",       int'(bus.mode),       modeExp);
        checkOutput("day_wrap",   int'(bus.day_wrap),   wrapExp);
        checkOutput("blink",      int'(bus.blink),      BLINK_EN ? blinkExp : 0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.tick_1hz = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;

        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        // 00:00:58 then two back-to-back ticks into 00:01:00.
        repeat (58) applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);

        // Hours wrap in set mode, ticks frozen, minutes wrap, exit clears seconds.
        repeat (5) applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);
        repeat (25) applyStimulus(0, 0, 0, 1);
        repeat (10) applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);
        repeat (61) applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0);

        // Simultaneous events.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);

        // Preload 23:59:59 and roll over the day.
        applyStimulus(0, 0, 1, 0);
        while (hh != 23) applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0);
        while (mm != 59) applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0);
        repeat (59) applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);

        // Blink in set modes, cleared on RUN, reset mid-SET_MINS.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        repeat (3) applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
